// File: rtl/eqed_pkg.sv
// ---------------------------------------------------------------------------
// eqed_pkg
// Shared definitions for the E-QED signature stages.
//   cap_state_t  : capture-window state (IDLE / CAPTURE / DONE)
//   DEF_SEED     : default signature seed
//   DEF_TAPS     : default MISR feedback mask
//   misr_next()  : one MISR step. Also used by the input-side compactor.
// No ports (package).
// ---------------------------------------------------------------------------
package eqed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

    localparam logic [5:0] DEF_SEED = 6'b000001;
    localparam logic [5:0] DEF_TAPS = 6'b110000;

    // Widest signature the shared step function handles. Callers zero-extend
    // their operands to this width and truncate the result back.
    localparam int MISR_MAX_W = 32;

    // One MISR step.
    //   next[0] = ^(sig & taps) ^ din[0]
    //   next[k] = sig[k-1] ^ (k even && k/2 < n_in ? din[k/2] : 0)
    // Observed bit j lands on signature bit 2*j. Interleaving the inputs with
    // plain shift positions keeps them apart inside the register.
    // Bits above the caller's width carry no meaning and are dropped by the
    // caller.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] din,
        input logic [MISR_MAX_W-1:0] taps,
        input int                    n_in
    );
        logic [MISR_MAX_W-1:0] nxt;
        nxt    = '0;
        nxt[0] = (^(sig & taps)) ^ din[0];
        for (int k = 1; k < MISR_MAX_W; k++) begin
            nxt[k] = sig[k-1];
            if (((k % 2) == 0) && ((k / 2) < n_in)) begin
                nxt[k] = nxt[k] ^ din[k/2];
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/eqed_sig_capture_if.sv
// ---------------------------------------------------------------------------
// eqed_sig_capture_if
// Bus between a harness and the signature capture stage.
//   start      harness -> stage   open a capture window (pulse)
//   obs_valid  harness -> stage   obs_in carries a sample this cycle
//   obs_in     harness -> stage   observed outputs of the module under check
//   exp_sig    harness -> stage   golden signature, sampled at window close
//   sig        stage -> harness   current signature register
//   busy       stage -> harness   window open
//   done       stage -> harness   result valid (held until next start / rst)
//   match      stage -> harness   signature matched exp_sig at close
//   count      stage -> harness   samples taken in the current window
// Modports: master (harness side), slave (capture stage).
// ---------------------------------------------------------------------------
interface eqed_sig_capture_if #(
    parameter int N_IN   = 3,
    parameter int MISR_W = 6,
    parameter int WINDOW = 5,
    parameter int CNT_W  = $clog2(WINDOW + 1)
);
    logic              start;
    logic              obs_valid;
    logic [N_IN-1:0]   obs_in;
    logic [MISR_W-1:0] exp_sig;
    logic [MISR_W-1:0] sig;
    logic              busy;
    logic              done;
    logic              match;
    logic [CNT_W-1:0]  count;

    modport master (
        output start, obs_valid, obs_in, exp_sig,
        input  sig, busy, done, match, count
    );

    modport slave (
        input  start, obs_valid, obs_in, exp_sig,
        output sig, busy, done, match, count
    );

endinterface

// File: rtl/eqed_misr.sv
// ---------------------------------------------------------------------------
// eqed_misr
// Multiple-input signature register. It is shared by the output-side capture
// stage and by the input-side compactor.
//   clk          in   clock
//   rst          in   synchronous active-high reset (sig -> SEED)
//   load_seed_i  in   reload SEED (takes priority over step_i)
//   step_i       in   fold din_i into the signature
//   din_i        in   N_IN observed bits; bit j enters signature bit 2*j
//   sig_o        out  signature register
//   nxt_o        out  signature after a step with the current din_i
//                     (combinational look-ahead, used for the close compare)
// ---------------------------------------------------------------------------
module eqed_misr
    import eqed_pkg::*;
#(
    parameter int                N_IN   = 3,
    parameter int                MISR_W = 6,
    parameter logic [MISR_W-1:0] TAPS   = MISR_W'(DEF_TAPS),
    parameter logic [MISR_W-1:0] SEED   = MISR_W'(DEF_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_seed_i,
    input  logic              step_i,
    input  logic [N_IN-1:0]   din_i,
    output logic [MISR_W-1:0] sig_o,
    output logic [MISR_W-1:0] nxt_o
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;
    logic [MISR_W-1:0] nxt;

    assign nxt = MISR_W'(misr_next(MISR_MAX_W'(sig_q), MISR_MAX_W'(din_i),
                                   MISR_MAX_W'(TAPS), N_IN));

    always_comb begin
        sig_d = sig_q;
        if (load_seed_i) begin
            sig_d = SEED;
        end else if (step_i) begin
            sig_d = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;
    assign nxt_o = nxt;

endmodule

// File: rtl/eqed_sig_capture.sv
// ---------------------------------------------------------------------------
// eqed_sig_capture
// Downstream signature stage for E-QED harnesses. When start arrives it opens
// a window of WINDOW valid samples. Each sample is folded into a MISR. At the
// last sample the resulting signature is compared with exp_sig, and done/match
// are reported until the next start or reset.
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of eqed_sig_capture_if
//         (start, obs_valid, obs_in, exp_sig in;
//          sig, busy, done, match, count out)
// Every output comes straight from a register.
// Constraint: 2*N_IN <= MISR_W. Inputs beyond that width would be lost.
// ---------------------------------------------------------------------------
module eqed_sig_capture
    import eqed_pkg::*;
#(
    parameter int                N_IN   = 3,
    parameter int                MISR_W = 6,
    parameter logic [MISR_W-1:0] TAPS   = MISR_W'(DEF_TAPS),
    parameter logic [MISR_W-1:0] SEED   = MISR_W'(DEF_SEED),
    parameter int                WINDOW = 5
) (
    input  logic                clk,
    input  logic                rst,
    eqed_sig_capture_if.slave   bus
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WINDOW);

    cap_state_t        state_q;
    logic [CNT_W-1:0]  count_q;
    logic              busy_q;
    logic              done_q;
    logic              match_q;

    logic              accept;
    logic              reseed;
    logic              last;
    logic [MISR_W-1:0] sig;
    logic [MISR_W-1:0] sig_nxt;

    // A sample counts only while the window is open. That covers the start
    // cycle too, because the state is still IDLE/DONE then.
    assign accept = (state_q == ST_CAPTURE) && bus.obs_valid;
    // start re-arms from IDLE or DONE. It is ignored while a window runs.
    assign reseed = (state_q != ST_CAPTURE) && bus.start;
    assign last   = accept && (count_q == CNT_LAST);

    eqed_misr #(
        .N_IN   (N_IN),
        .MISR_W (MISR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_misr (
        .clk         (clk),
        .rst         (rst),
        .load_seed_i (reseed),
        .step_i      (accept),
        .din_i       (bus.obs_in),
        .sig_o       (sig),
        .nxt_o       (sig_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q <= ST_CAPTURE;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        match_q <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        if (count_q != CNT_FULL) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        if (last) begin
                            // The closing sample is part of the signature, so
                            // compare the look-ahead value rather than sig.
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            match_q <= (sig_nxt == bus.exp_sig);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    match_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sig   = sig;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.match = match_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_eqed_sig_capture.sv
// ---------------------------------------------------------------------------
// tb_eqed_sig_capture
// Bench for eqed_sig_capture. It instantiates two copies: a default one with
// WINDOW=5 and a short one with WINDOW=1.
// ---------------------------------------------------------------------------
module tb_eqed_sig_capture;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    eqed_sig_capture_if #(.N_IN(3), .MISR_W(6), .WINDOW(5)) bus5 ();
    eqed_sig_capture_if #(.N_IN(3), .MISR_W(6), .WINDOW(1)) bus1 ();

    eqed_sig_capture #(.WINDOW(5)) u5 (.clk(clk), .rst(rst), .bus(bus5));
    eqed_sig_capture #(.WINDOW(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    // Reference signature step: shift left and feed back the tapped bits.
    // obs bit j is XORed into position 2*j.
    function automatic logic [5:0] mstep(input logic [5:0] s, input logic [2:0] d);
        logic fb;
        fb = s[5] ^ s[4];
        return {s[4:0], fb} ^ {1'b0, d[2], 1'b0, d[1], 1'b0, d[0]};
    endfunction

    // Behavioural model of the WINDOW=5 instance.
    bit         armed = 0;
    bit         m_open, m_done, m_match;
    logic [5:0] m_sig;
    int         m_n;

    always @(posedge clk) begin
        if (rst) begin
            armed   = 1;
            m_open  = 0;
            m_done  = 0;
            m_match = 0;
            m_sig   = 6'h01;
            m_n     = 0;
        end else if (!m_open) begin
            if (bus5.start) begin
                m_open  = 1;
                m_done  = 0;
                m_match = 0;
                m_sig   = 6'h01;
                m_n     = 0;
            end
        end else if (bus5.obs_valid) begin
            m_sig = mstep(m_sig, bus5.obs_in);
            m_n   = m_n + 1;
            if (m_n == 5) begin
                m_open  = 0;
                m_done  = 1;
                m_match = (m_sig == bus5.exp_sig);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("cmp_sig",   32'(bus5.sig),   32'(m_sig));
            chk("cmp_busy",  32'(bus5.busy),  32'(m_open));
            chk("cmp_done",  32'(bus5.done),  32'(m_done));
            chk("cmp_match", 32'(bus5.match), 32'(m_match));
            chk("cmp_count", 32'(bus5.count), 32'(m_n));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [5:0] tr [5];

    // Runs one WINDOW=5 capture with obs_in=0 and exp_sig=0x21. It can insert
    // a stall gap, and it can pulse start in the middle of the window. It
    // returns the number of cycles from the start cycle until done is seen.
    task automatic run_window(input int gap_at, input int gap_len, input bit start_mid,
                              input string tag, output int ticks);
        int s;
        int g;
        bus5.start     = 1'b1;
        bus5.obs_valid = 1'b0;
        bus5.obs_in    = 3'b000;
        bus5.exp_sig   = 6'h21;
        tick();
        ticks = 1;
        bus5.start = 1'b0;
        s = 0;
        g = 0;
        while (!bus5.done && ticks < 40) begin
            if (s == gap_at && g < gap_len) begin
                bus5.obs_valid = 1'b0;
                g++;
            end else begin
                bus5.obs_valid = 1'b1;
            end
            bus5.start = start_mid && (s == 1 || s == 2);
            tick();
            ticks++;
            if (bus5.obs_valid) begin
                if (s < 5) chk({tag, "_trace"}, 32'(bus5.sig), 32'(tr[s]));
                s++;
                if (start_mid && s == 3) chk({tag, "_count3"}, 32'(bus5.count), 32'd3);
            end
        end
        bus5.start     = 1'b0;
        bus5.obs_valid = 1'b0;
        chk({tag, "_done"},  32'(bus5.done),  32'd1);
        chk({tag, "_match"}, 32'(bus5.match), 32'd1);
        chk({tag, "_sig"},   32'(bus5.sig),   32'h21);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        tr[0] = 6'h02; tr[1] = 6'h04; tr[2] = 6'h08; tr[3] = 6'h10; tr[4] = 6'h21;
        rst = 1'b1;
        bus5.start = 0; bus5.obs_valid = 0; bus5.obs_in = 0; bus5.exp_sig = 0;
        bus1.start = 0; bus1.obs_valid = 0; bus1.obs_in = 0; bus1.exp_sig = 0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();

        // Reset / idle state
        chk("t1_sig",   32'(bus5.sig),   32'h01);
        chk("t1_busy",  32'(bus5.busy),  32'd0);
        chk("t1_done",  32'(bus5.done),  32'd0);
        chk("t1_match", 32'(bus5.match), 32'd0);
        chk("t1_count", 32'(bus5.count), 32'd0);
        chk("t1_sig_w1", 32'(bus1.sig),  32'h01);

        // WINDOW=1 instance
        bus1.start = 1; tick(); bus1.start = 0;
        chk("t2_busy", 32'(bus1.busy), 32'd1);
        bus1.obs_valid = 1; bus1.obs_in = 3'b111; bus1.exp_sig = 6'h17;
        tick(); bus1.obs_valid = 0;
        chk("t2a_sig",   32'(bus1.sig),   32'h17);
        chk("t2a_done",  32'(bus1.done),  32'd1);
        chk("t2a_match", 32'(bus1.match), 32'd1);
        bus1.start = 1; tick(); bus1.start = 0;
        chk("t2_done_clr", 32'(bus1.done), 32'd0);
        chk("t2_reseed",   32'(bus1.sig),  32'h01);
        bus1.obs_valid = 1; bus1.obs_in = 3'b001; bus1.exp_sig = 6'h17;
        tick(); bus1.obs_valid = 0;
        chk("t2b_sig",   32'(bus1.sig),   32'h03);
        chk("t2b_done",  32'(bus1.done),  32'd1);
        chk("t2b_match", 32'(bus1.match), 32'd0);

        // Plain window
        run_window(99, 0, 0, "t3", t);
        chk("t3_latency", 32'(t), 32'd6);
        chk("t3_model", 32'(m_sig), 32'h21);
        tick();
        chk("t3_hold", 32'(bus5.done), 32'd1);

        // Stall of two cycles mid-window
        run_window(2, 2, 0, "t4", t);
        chk("t4_latency", 32'(t), 32'd8);

        // Reset mid-window
        bus5.start = 1; tick(); bus5.start = 0;
        bus5.obs_valid = 1; bus5.obs_in = 3'b000;
        tick(); tick(); tick();
        chk("t5_count_pre", 32'(bus5.count), 32'd3);
        rst = 1; tick(); rst = 0; bus5.obs_valid = 0;
        chk("t5_sig",   32'(bus5.sig),   32'h01);
        chk("t5_count", 32'(bus5.count), 32'd0);
        chk("t5_busy",  32'(bus5.busy),  32'd0);
        chk("t5_done",  32'(bus5.done),  32'd0);
        tick();
        run_window(99, 0, 0, "t5r", t);
        chk("t5r_latency", 32'(t), 32'd6);

        // start ignored in CAPTURE, then back-to-back windows from DONE
        run_window(99, 0, 1, "t6a", t);
        chk("t6a_latency", 32'(t), 32'd6);
        run_window(99, 0, 0, "t6b", t);
        chk("t6b_latency", 32'(t), 32'd6);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 63) == 0);
            bus5.start     = ($urandom_range(0, 7) == 0);
            bus5.obs_valid = ($urandom_range(0, 3) != 0);
            bus5.obs_in    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0)
                bus5.exp_sig = mstep(m_sig, bus5.obs_in);
            else
                bus5.exp_sig = 6'($urandom_range(0, 63));
            tick();
        end
        rst = 0; bus5.start = 0; bus5.obs_valid = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
